next_pc_unit: RTL and testbench

- Parametrised successor to the single-cycle jump-target concatenation logic.
- Owns the architectural PC register and selects the next PC every cycle. Sources: sequential, conditional branch, J/JAL pseudo-direct jump, JR register jump.
- Adds stall hold, registered redirect flag, sticky misalignment error and an optional return-address stack.
- Sits between the control/ALU outputs and the instruction memory address port.

---
 rtl/next_pc_pkg.sv | 22 ++
 rtl/next_pc_unit_ret_addr_stack.sv | 81 ++++++++
 rtl/next_pc_unit.sv | 139 +++++++++++++
 tb/tb_next_pc_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_pkg.sv
// Shared types and constants for the next-PC unit and its return-address stack.
package next_pc_pkg;

    localparam int DEFAULT_ADDR_W      = 32;
    localparam int DEFAULT_INSTR_IDX_W = 26;
    localparam int DEFAULT_RAS_DEPTH   = 4;
    localparam int INSTR_BYTES         = 4;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

    // A byte address is misaligned for instruction fetch when either low bit is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_unit_ret_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry
// and the count saturates; a pop when empty is ignored; pop wins over push.
// The top entry and the valid flag are held in registers so the outputs are glitch-free.
module ret_addr_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] top_r;
    logic              valid_r;
    logic [PTR_W-1:0]  top_ptr_s;
    logic [PTR_W-1:0]  below_top_ptr_s;

    // wr_ptr_r always points at the slot the next push will write.
    assign top_ptr_s       = wr_ptr_r - PTR_ONE;
    assign below_top_ptr_s = wr_ptr_r - PTR_TWO;

    // Storage, pointer, count and registered top/valid update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ADDR_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
            top_r    <= {ADDR_W{1'b0}};
            valid_r  <= 1'b0;
        end else if (pop) begin
            if (count_r != CNT_ZERO) begin
                wr_ptr_r <= top_ptr_s;
                count_r  <= count_r - CNT_ONE;
                if (count_r > CNT_ONE) begin
                    top_r   <= mem_r[below_top_ptr_s];
                    valid_r <= 1'b1;
                end else begin
                    top_r   <= {ADDR_W{1'b0}};
                    valid_r <= 1'b0;
                end
            end else begin
                wr_ptr_r <= wr_ptr_r;
                count_r  <= count_r;
            end
        end else if (push) begin
            mem_r[wr_ptr_r] <= push_addr;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            top_r           <= push_addr;
            valid_r         <= 1'b1;
            if (count_r != CNT_FULL) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end else begin
            wr_ptr_r <= wr_ptr_r;
            count_r  <= count_r;
        end
    end

    assign top_addr = top_r;
    assign valid    = valid_r;

endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register and next-PC selection (sequential, branch,
// J/JAL pseudo-direct, JR register jump) with stall hold, redirect flag and
// sticky JR misalignment error.
// Optional return-address stack enabled by defining NEXT_PC_RAS_EN.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter int                INSTR_IDX_W = DEFAULT_INSTR_IDX_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
    parameter int                RAS_DEPTH   = DEFAULT_RAS_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   branch_i,
    input  logic [15:0]            branch_off_i,
    input  logic                   jump_i,
    input  logic                   jal_i,
    input  logic                   jr_i,
    input  logic [ADDR_W-1:0]      jr_target_i,
    input  logic [INSTR_IDX_W-1:0] instr_idx_i,
    output logic [ADDR_W-1:0]      pc_o,
    output logic [ADDR_W-1:0]      pc_plus4_o,
    output logic [ADDR_W-1:0]      link_addr_o,
    output logic                   redirect_o,
    output logic                   misalign_o,
    output logic [ADDR_W-1:0]      ras_top_o,
    output logic                   ras_valid_o
);

    // Upper PC bits kept by a pseudo-direct jump.
    localparam int REGION_W = ADDR_W - INSTR_IDX_W - 2;

    // Parameter sanity checks at elaboration.
    if (ADDR_W != INSTR_IDX_W + 6) begin : g_bad_addr_w
        $error("next_pc_unit: ADDR_W must equal INSTR_IDX_W+6");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("next_pc_unit: RESET_PC must be word-aligned");
    end
    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
        $error("next_pc_unit: RAS_DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] pc_r;
    logic              redirect_r;
    logic              misalign_r;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] br_off_ext_s;
    logic [ADDR_W-1:0] br_target_s;
    logic [ADDR_W-1:0] jmp_target_s;
    logic [ADDR_W-1:0] jr_aligned_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              jr_misalign_s;
    pc_sel_e           pc_sel_s;

    assign pc_plus4_s    = pc_r + ADDR_W'(INSTR_BYTES);
    assign br_off_ext_s  = {{(ADDR_W-18){branch_off_i[15]}}, branch_off_i, 2'b00};
    assign br_target_s   = pc_plus4_s + br_off_ext_s;
    assign jmp_target_s  = {pc_plus4_s[ADDR_W-1 -: REGION_W], instr_idx_i, 2'b00};
    assign jr_aligned_s  = {jr_target_i[ADDR_W-1:2], 2'b00};
    assign jr_misalign_s = jr_i & is_misaligned(jr_target_i[1:0]);

    // Source priority: JR over J/JAL over branch over fall-through.
    always_comb begin
        pc_sel_s = SEL_SEQ;
        if (jr_i) begin
            pc_sel_s = SEL_JR;
        end else if (jump_i || jal_i) begin
            pc_sel_s = SEL_JMP;
        end else if (branch_i) begin
            pc_sel_s = SEL_BR;
        end else begin
            pc_sel_s = SEL_SEQ;
        end
    end

    // Next-PC multiplexer.
    always_comb begin
        next_pc_s = pc_plus4_s;
        case (pc_sel_s)
            SEL_SEQ: next_pc_s = pc_plus4_s;
            SEL_BR:  next_pc_s = br_target_s;
            SEL_JMP: next_pc_s = jmp_target_s;
            SEL_JR:  next_pc_s = jr_aligned_s;
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // PC, redirect and sticky misalignment state; a stall freezes all of it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_r       <= RESET_PC;
            redirect_r <= 1'b0;
            misalign_r <= 1'b0;
        end else if (!stall_i) begin
            pc_r       <= next_pc_s;
            redirect_r <= (pc_sel_s != SEL_SEQ);
            misalign_r <= misalign_r | jr_misalign_s;
        end else begin
            pc_r       <= pc_r;
            redirect_r <= redirect_r;
            misalign_r <= misalign_r;
        end
    end

    assign pc_o        = pc_r;
    assign pc_plus4_o  = pc_plus4_s;
    assign link_addr_o = pc_plus4_s;
    assign redirect_o  = redirect_r;
    assign misalign_o  = misalign_r;

`ifdef NEXT_PC_RAS_EN
    logic ras_push_s;
    logic ras_pop_s;

    // JR takes precedence, so a simultaneous JAL does not push.
    assign ras_pop_s  = ~stall_i & jr_i;
    assign ras_push_s = ~stall_i & jal_i & ~jr_i;

    ret_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_addr (pc_plus4_s),
        .top_addr  (ras_top_o),
        .valid     (ras_valid_o)
    );
`else
    assign ras_top_o   = {ADDR_W{1'b0}};
    assign ras_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus randomized
// traffic against a behavioural model of the PC rules and the return stack.
module tb_next_pc_unit;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [15:0] branch_off_i;
    logic        jump_i;
    logic        jal_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [25:0] instr_idx_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] link_addr_o;
    logic        redirect_o;
    logic        misalign_o;
    logic [31:0] ras_top_o;
    logic        ras_valid_o;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_redirect;
    logic        m_misalign;
    logic [31:0] m_ras[$];

    next_pc_unit #(
        .ADDR_W      (32),
        .INSTR_IDX_W (26),
        .RESET_PC    (32'h0000_0000),
        .RAS_DEPTH   (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .branch_off_i (branch_off_i),
        .jump_i       (jump_i),
        .jal_i        (jal_i),
        .jr_i         (jr_i),
        .jr_target_i  (jr_target_i),
        .instr_idx_i  (instr_idx_i),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .link_addr_o  (link_addr_o),
        .redirect_o   (redirect_o),
        .misalign_o   (misalign_o),
        .ras_top_o    (ras_top_o),
        .ras_valid_o  (ras_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] exp_ras_top();
`ifdef NEXT_PC_RAS_EN
        if (m_ras.size() > 0) return m_ras[$];
`endif
        return 32'h0;
    endfunction

    function automatic logic exp_ras_valid();
`ifdef NEXT_PC_RAS_EN
        return (m_ras.size() > 0);
`else
        return 1'b0;
`endif
    endfunction

    // Target the architecture would fetch next, from the instruction rules.
    function automatic logic [31:0] ref_target();
        int off;
        if (jr_i) return jr_target_i & 32'hFFFF_FFFC;
        if (jump_i || jal_i) return ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, instr_idx_i} * 32'd4);
        if (branch_i) begin
            off = int'($signed(branch_off_i));
            return m_pc + 32'd4 + 32'(off * 4);
        end
        return m_pc + 32'd4;
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        logic [31:0] nxt;
        logic        nred;
        logic        nmis;
        nxt  = m_pc;
        nred = m_redirect;
        nmis = m_misalign;
        if (!stall_i) begin
            nxt  = ref_target();
            nred = jr_i | jump_i | jal_i | branch_i;
            nmis = m_misalign | (jr_i && (jr_target_i[1:0] != 2'b00));
            if (jr_i) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end else if (jal_i) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
        end
        @(posedge clk_i);
        #1;
        m_pc       = nxt;
        m_redirect = nred;
        m_misalign = nmis;
    endtask

    task automatic clear_inputs();
        stall_i      = 1'b0;
        branch_i     = 1'b0;
        branch_off_i = 16'h0000;
        jump_i       = 1'b0;
        jal_i        = 1'b0;
        jr_i         = 1'b0;
        jr_target_i  = 32'h0;
        instr_idx_i  = 26'h0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_i = 1'b0;
        #2;
        m_pc       = 32'h0;
        m_redirect = 1'b0;
        m_misalign = 1'b0;
        m_ras.delete();
        #2;
        rst_i = 1'b1;
    endtask

    task automatic set_pc(input logic [31:0] addr);
        jr_i        = 1'b1;
        jr_target_i = addr;
        tick();
        jr_i        = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b0;
        #2;
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
        checks++; if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4_o, 32'h4); end
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", redirect_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
        checks++; if (ras_valid_o !== 1'b0 || ras_top_o !== 32'h0) begin errors++; $display("FAIL reset_ras: got %b/%h expected 0/0", ras_valid_o, ras_top_o); end
        m_pc = 32'h0; m_redirect = 1'b0; m_misalign = 1'b0; m_ras.delete();
        #2;
        rst_i = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc_o !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc_o, 32'(i * 4)); end
            checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL seq_redirect[%0d]: got %b expected 0", i, redirect_o); end
            checks++; if (link_addr_o !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_link[%0d]: got %h expected %h", i, link_addr_o, 32'(i * 4 + 4)); end
        end
    endtask

    task automatic test_branch_jump_priority();
        set_pc(32'h0000_0100);
        branch_i = 1'b1; branch_off_i = 16'hFFFF;
        tick();
        checks++; if (pc_o !== 32'h0000_0100) begin errors++; $display("FAIL branch_back: got %h expected %h", pc_o, 32'h0000_0100); end
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL branch_redirect: got %b expected 1", redirect_o); end
        jump_i = 1'b1; instr_idx_i = 26'h40; branch_off_i = 16'h0010;
        tick();
        checks++; if (pc_o !== 32'h0000_0100) begin errors++; $display("FAIL jump_over_branch: got %h expected %h", pc_o, 32'h0000_0100); end
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL jump_redirect: got %b expected 1", redirect_o); end
        jump_i = 1'b0; branch_off_i = 16'h0003;
        tick();
        checks++; if (pc_o !== 32'h0000_0110) begin errors++; $display("FAIL branch_fwd: got %h expected %h", pc_o, 32'h0000_0110); end
        branch_i = 1'b0; jump_i = 1'b1; jr_i = 1'b1; jr_target_i = 32'h0000_0500;
        tick();
        checks++; if (pc_o !== 32'h0000_0500) begin errors++; $display("FAIL jr_over_jump: got %h expected %h", pc_o, 32'h0000_0500); end
        clear_inputs();
        tick();
        checks++; if (pc_o !== 32'h0000_0504 || redirect_o !== 1'b0) begin errors++; $display("FAIL seq_after_redirect: got %h/%b expected %h/0", pc_o, redirect_o, 32'h0000_0504); end
    endtask

    task automatic test_jump_region();
        set_pc(32'h8000_0010);
        jump_i = 1'b1; instr_idx_i = 26'h3FF_FFFF;
        tick();
        checks++; if (pc_o !== 32'h8FFF_FFFC) begin errors++; $display("FAIL jump_region: got %h expected %h", pc_o, 32'h8FFF_FFFC); end
        clear_inputs();
    endtask

    task automatic test_jr_misalign();
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_clean: got %b expected 0", misalign_o); end
        set_pc(32'h0000_2003);
        checks++; if (pc_o !== 32'h0000_2000) begin errors++; $display("FAIL jr_align: got %h expected %h", pc_o, 32'h0000_2000); end
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b expected 1", misalign_o); end
        set_pc(32'h0000_3000);
        tick();
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b expected 1", misalign_o); end
        pulse_reset();
        checks++; if (misalign_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL misalign_cleared: got %b/%h expected 0/0", misalign_o, pc_o); end
        tick();
    endtask

    task automatic test_stall();
        set_pc(32'h0000_0400);
        stall_i = 1'b1; jump_i = 1'b1; instr_idx_i = 26'h123; jr_i = 1'b1; jr_target_i = 32'h0000_0007;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc_o !== 32'h0000_0400) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_o, 32'h0000_0400); end
            checks++; if (redirect_o !== 1'b1 || misalign_o !== 1'b0) begin errors++; $display("FAIL stall_flags[%0d]: got %b/%b expected 1/0", i, redirect_o, misalign_o); end
        end
        clear_inputs();
        tick();
        checks++; if (pc_o !== 32'h0000_0404 || redirect_o !== 1'b0) begin errors++; $display("FAIL unstall: got %h/%b expected %h/0", pc_o, redirect_o, 32'h0000_0404); end
        set_pc(32'hFFFF_FFFC);
        tick();
        checks++; if (pc_o !== 32'h0 || redirect_o !== 1'b0) begin errors++; $display("FAIL wrap: got %h/%b expected 0/0", pc_o, redirect_o); end
        set_pc(32'h0000_0800);
        stall_i = 1'b1;
        pulse_reset();
        checks++; if (pc_o !== 32'h0 || redirect_o !== 1'b0) begin errors++; $display("FAIL reset_in_stall: got %h/%b expected 0/0", pc_o, redirect_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_ras();
        logic [31:0] exp_tops [3];
        exp_tops[0] = 32'h44; exp_tops[1] = 32'h34; exp_tops[2] = 32'h24;
        set_pc(32'h0000_0010);
`ifdef NEXT_PC_RAS_EN
        for (int k = 1; k <= 5; k++) begin
            jal_i = 1'b1; instr_idx_i = 26'((k + 1) * 4);
            tick();
            checks++; if (pc_o !== 32'((k + 1) * 16)) begin errors++; $display("FAIL jal_pc[%0d]: got %h expected %h", k, pc_o, 32'((k + 1) * 16)); end
            checks++; if (ras_top_o !== 32'(k * 16 + 4) || ras_valid_o !== 1'b1) begin errors++; $display("FAIL ras_push[%0d]: got %h/%b expected %h/1", k, ras_top_o, ras_valid_o, 32'(k * 16 + 4)); end
        end
        jal_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            jr_i = 1'b1; jr_target_i = 32'(32'h1000 + k * 16);
            tick();
            if (k < 3) begin
                checks++; if (ras_top_o !== exp_tops[k] || ras_valid_o !== 1'b1) begin errors++; $display("FAIL ras_pop[%0d]: got %h/%b expected %h/1", k, ras_top_o, ras_valid_o, exp_tops[k]); end
            end else begin
                checks++; if (ras_valid_o !== 1'b0 || ras_top_o !== 32'h0) begin errors++; $display("FAIL ras_empty[%0d]: got %h/%b expected 0/0", k, ras_top_o, ras_valid_o); end
            end
        end
        jr_i = 1'b0; jal_i = 1'b1; instr_idx_i = 26'h100;
        tick();
        checks++; if (ras_valid_o !== 1'b1 || ras_top_o !== 32'h0000_1044) begin errors++; $display("FAIL ras_repush: got %h/%b expected %h/1", ras_top_o, ras_valid_o, 32'h0000_1044); end
        jr_i = 1'b1; jr_target_i = 32'h0000_2000;
        tick();
        checks++; if (ras_valid_o !== 1'b0 || pc_o !== 32'h0000_2000) begin errors++; $display("FAIL jal_jr_pop: got %b/%h expected 0/%h", ras_valid_o, pc_o, 32'h0000_2000); end
`else
        jal_i = 1'b1; instr_idx_i = 26'h8;
        tick();
        checks++; if (ras_valid_o !== 1'b0 || ras_top_o !== 32'h0) begin errors++; $display("FAIL ras_disabled: got %h/%b expected 0/0", ras_top_o, ras_valid_o); end
`endif
        clear_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            stall_i      = ($urandom_range(0, 4) == 0);
            branch_i     = ($urandom_range(0, 2) == 0);
            jump_i       = ($urandom_range(0, 5) == 0);
            jal_i        = ($urandom_range(0, 5) == 0);
            jr_i         = ($urandom_range(0, 4) == 0);
            branch_off_i = 16'($urandom);
            instr_idx_i  = 26'($urandom);
            jr_target_i  = $urandom;
            if ($urandom_range(0, 7) != 0) jr_target_i[1:0] = 2'b00;
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
                checks++; if (pc_o !== 32'h0 || misalign_o !== 1'b0) begin errors++; $display("FAIL rnd_reset[%0d]: got %h/%b expected 0/0", n, pc_o, misalign_o); end
            end
            tick();
            checks++; if (pc_o !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc_o, m_pc); end
            checks++; if (pc_plus4_o !== m_pc + 32'd4 || link_addr_o !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h/%h expected %h", n, pc_plus4_o, link_addr_o, m_pc + 32'd4); end
            checks++; if (redirect_o !== m_redirect || misalign_o !== m_misalign) begin errors++; $display("FAIL rnd_flags[%0d]: got %b/%b expected %b/%b", n, redirect_o, misalign_o, m_redirect, m_misalign); end
            checks++; if (ras_top_o !== exp_ras_top() || ras_valid_o !== exp_ras_valid()) begin errors++; $display("FAIL rnd_ras[%0d]: got %h/%b expected %h/%b", n, ras_top_o, ras_valid_o, exp_ras_top(), exp_ras_valid()); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch_jump_priority();
        test_jump_region();
        test_jr_misalign();
        test_stall();
        test_ras();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
